// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the core's load/store data bus.
// One request at a time. A request is held for LATENCY cycles. Then a store is
// committed, or a load returns data that is sign- or zero-extended as req_size_i asks.
// Optional feature macro: MISALIGN_ERR_EN. When it is defined, misaligned and
// out-of-range accesses raise rsp_err_o. When it is undefined, misaligned
// accesses are forced aligned.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,  // assumed word aligned
  parameter int unsigned LATENCY     = 2               // 1..15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_size_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef enum logic [2:0] {K_B, K_H, K_W, K_BU, K_HU} kind_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q, valid_q, err_q;
  logic [31:0] rdata_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  size_q;

  logic [31:0] mem [DEPTH_WORDS];

  // The access being served. In IDLE it comes straight from the request,
  // because LATENCY=1 commits on the accept edge. Otherwise it is the latched copy.
  logic        a_we;
  logic [31:0] a_addr, a_wdata;
  logic [2:0]  a_size;
  assign a_we    = (state_q == S_IDLE) ? req_we_i    : we_q;
  assign a_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
  assign a_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;
  assign a_size  = (state_q == S_IDLE) ? req_size_i  : size_q;

  logic accept, commit;
  assign accept = req_valid_i && ready_q;
  assign commit = (state_q == S_WAIT && cnt_q == 4'd0) || (accept && LATENCY == 1);

  // Word index relative to BASE_ADDR, plus a range check.
  logic [29:0]      word_off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  assign word_off = a_addr[31:2] - BASE_ADDR[31:2];
  assign in_range = (a_addr >= BASE_ADDR) && ({2'b00, word_off} < DEPTH_WORDS);
  assign idx      = word_off[IDX_W-1:0];

  // Decode funct3 into an access kind. Undefined codes, and any 1xx code on a store, act as W.
  kind_e kind;
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    kind = K_W;
    if (a_we) begin
      case (a_size)
        3'b000:  kind = K_B;
        3'b001:  kind = K_H;
        default: kind = K_W;
      endcase
    end else begin
      case (a_size)
        3'b000:  kind = K_B;
        3'b001:  kind = K_H;
        3'b100:  kind = K_BU;
        3'b101:  kind = K_HU;
        default: kind = K_W;
      endcase
    end
  end

  // Byte lane of the access. Halfwords and words are forced onto their natural alignment.
  logic [1:0] lane;
  always_comb begin
    lane = 2'b00;
    case (kind)
      K_B, K_BU: lane = a_addr[1:0];
      K_H, K_HU: lane = {a_addr[1], 1'b0};
      default:   lane = 2'b00;
    endcase
  end

  // The error condition gates both the RAM write and the load data.
  logic acc_err;
`ifdef MISALIGN_ERR_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (kind)
      K_H, K_HU: misaligned = a_addr[0];
      K_W:       misaligned = |a_addr[1:0];
      default:   misaligned = 1'b0;
    endcase
  end
  assign acc_err = misaligned || !in_range;
`else
  assign acc_err = 1'b0;
`endif

  logic ok;
  assign ok = in_range && !acc_err;

  // Store byte enables and replicated store data.
  logic [3:0]  wmask;
  logic [31:0] wbytes;
  always_comb begin
    wmask  = 4'b1111;
    wbytes = a_wdata;
    case (kind)
      K_B: begin
        wmask  = 4'b0001 << lane;
        wbytes = {4{a_wdata[7:0]}};
      end
      K_H: begin
        wmask  = 4'b0011 << lane;
        wbytes = {2{a_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension. Stores and faulting accesses return 0.
  logic [31:0] rd_word, shifted, ld_ext, rd_next;
  assign rd_word = mem[idx];
  assign shifted = rd_word >> {lane, 3'b000};
  always_comb begin
    case (kind)
      K_B:     ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      K_BU:    ld_ext = {24'h0, shifted[7:0]};
      K_H:     ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      K_HU:    ld_ext = {16'h0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end
  assign rd_next = (a_we || !ok) ? 32'h0 : ld_ext;

  // RAM write port: fires once, on the edge entering RESP. Reset blocks it.
  // NOTE: the RAM array has no reset, so it can map onto block RAM. Only control state is reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && a_we && ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wbytes[8*b +: 8];
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments here let every register see pre-edge values.
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 3'b000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            size_q  <= req_size_i;
            ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q <= S_RESP;
              valid_q <= 1'b1;
              rdata_q <= rd_next;
              err_q   <= acc_err;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
            valid_q <= 1'b1;
            rdata_q <= rd_next;
            err_q   <= acc_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (LATENCY=2, DEPTH_WORDS=1024, BASE_ADDR=0).
// Expectations depend on MISALIGN_ERR_EN when that macro is defined.
module tb_data_mem_responder;

  localparam int LAT = 2;
`ifdef MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_size = 3'b010;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(LAT)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_size_i (req_size),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles after the accept edge until rsp_valid rises (bounded).
  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Full transaction: wait for ready, accept, wait for the response, check it, consume it.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] size,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0;
    wait_rsp(n);
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // 1. Reset held 3 cycles, then released.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'h0);

    // 2. Word store, then load back.
    xact("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    xact("lw10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

    // 3. Byte store into the top lane, then sub-word loads.
    xact("sw10b", 1'b1, 32'h10, 32'h11223344, 3'b010, 32'h0, 1'b0);
    xact("sb13", 1'b1, 32'h13, 32'h00000080, 3'b000, 32'h0, 1'b0);
    xact("lb13", 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0);
    xact("lbu13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h00000080, 1'b0);
    xact("lw10c", 1'b0, 32'h10, 32'h0, 3'b010, 32'h80223344, 1'b0);
    xact("lh12", 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF8022, 1'b0);
    xact("lhu12", 1'b0, 32'h12, 32'h0, 3'b101, 32'h00008022, 1'b0);
    xact("lb10", 1'b0, 32'h10, 32'h0, 3'b000, 32'h00000044, 1'b0);

    // Halfword store into the upper half.
    xact("sw14", 1'b1, 32'h14, 32'h00000000, 3'b010, 32'h0, 1'b0);
    xact("sh16", 1'b1, 32'h16, 32'h1234BEEF, 3'b001, 32'h0, 1'b0);
    xact("lw14", 1'b0, 32'h14, 32'h0, 3'b010, 32'hBEEF0000, 1'b0);

    // Undefined sizes act as W: a 1xx store and an 011 load.
    xact("sx18", 1'b1, 32'h18, 32'h12345678, 3'b100, 32'h0, 1'b0);
    xact("lx18", 1'b0, 32'h18, 32'h0, 3'b011, 32'h12345678, 1'b0);

    // 4. Response backpressure. req_valid stays high with a second request pending.
    req_we = 1'b0; req_addr = 32'h10; req_size = 3'b010; req_valid = 1'b1;
    tick();
    req_addr = 32'h18;
    wait_rsp(n);
    check("bp_lat", 32'(n), 32'(LAT));
    check("bp_rdata0", rsp_rdata, 32'h80223344);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rdata", rsp_rdata, 32'h80223344);
      check("bp_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_idle_ready", 32'(req_ready), 32'h1);
    check("bp_idle_valid", 32'(rsp_valid), 32'h0);
    tick();
    req_valid = 1'b0;
    check("bp_accept2", 32'(req_ready), 32'h0);
    wait_rsp(n);
    check("bp2_lat", 32'(n), 32'(LAT));
    check("bp2_rdata", rsp_rdata, 32'h12345678);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // 5. Reset while a store waits: the store is discarded.
    xact("sw30", 1'b1, 32'h30, 32'hA5A5A5A5, 3'b010, 32'h0, 1'b0);
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h5A5A5A5A; req_size = 3'b010;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rw_wait_ready", 32'(req_ready), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_ready", 32'(req_ready), 32'h1);
    check("rw_valid", 32'(rsp_valid), 32'h0);
    tick();
    check("rw_valid2", 32'(rsp_valid), 32'h0);
    tick();
    check("rw_valid3", 32'(rsp_valid), 32'h0);
    xact("lw30", 1'b0, 32'h30, 32'h0, 3'b010, 32'hA5A5A5A5, 1'b0);

    // 6. Misaligned word load.
    xact("sw20", 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);
    xact("lw22", 1'b0, 32'h22, 32'h0, 3'b010, ERR_EN ? 32'h0 : 32'hCAFEF00D, ERR_EN);

    // Out of range: the store is dropped and the load returns 0.
    xact("sw_oor", 1'b1, 32'h1000, 32'hFFFFFFFF, 3'b010, 32'h0, ERR_EN);
    xact("lw_oor", 1'b0, 32'h1000, 32'h0, 3'b010, 32'h0, ERR_EN);
    xact("lw_last", 1'b1, 32'hFFC, 32'h0BADF00D, 3'b010, 32'h0, 1'b0);
    xact("lw_lastr", 1'b0, 32'hFFC, 32'h0, 3'b010, 32'h0BADF00D, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
